// File: rtl/induct_stop_ctrl_if.sv
// Handshake bundle between the inductive-stop controller and its surroundings.
// master drives the sensor/arm inputs, slave is the controller itself.
interface induct_stop_ctrl_if;
    logic       on_induct;
    logic       enable;
    logic       motor_stop;
    logic       detect_pulse;
    logic       lockout;
    logic [2:0] state;
    logic [7:0] detect_count;

    modport master (
        output on_induct, enable,
        input  motor_stop, detect_pulse, lockout, state, detect_count
    );
    modport slave (
        input  on_induct, enable,
        output motor_stop, detect_pulse, lockout, state, detect_count
    );
endinterface

// File: rtl/induct_stop_ctrl.sv
// Debounced inductive-target detector: qualifies a metal detection, holds the
// motor stopped for a fixed time, then ignores the sensor while driving off.
module induct_stop_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int LOCKOUT_CYCLES  = 50000000,
    parameter int CNT_W           = 27
) (
    input  logic               clk,
    input  logic               reset,
    induct_stop_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        QUAL    = 3'd2,
        STOP    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             sensed;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             motor_stop_q, motor_stop_d;
    logic             lockout_q, lockout_d;
    logic             detect_pulse_q, detect_pulse_d;
    logic [7:0]       detect_count_q, detect_count_d;

    // Sync flops reset to "clear" so leaving reset cannot look like metal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.on_induct;
            sync2_q <= sync1_q;
        end
    end

    assign sensed = ~sync2_q;

    always_comb begin
        state_d        = state_q;
        detect_pulse_d = 1'b0;
        detect_count_d = detect_count_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (sensed) state_d = QUAL;
                QUAL: begin
                    if (!sensed) begin
                        state_d = ARMED;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d        = STOP;
                        detect_pulse_d = 1'b1;
                        if (detect_count_q != 8'hFF)
                            detect_count_d = detect_count_q + 8'd1;
                    end
                end
                STOP:    if (cnt_q == HOLD_LAST) state_d = LOCKOUT;
                LOCKOUT: if (cnt_q == LOCK_LAST) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == QUAL || state_q == STOP || state_q == LOCKOUT)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        // Outputs follow the next state so they line up with the state register.
        motor_stop_d = (state_d == STOP);
        lockout_d    = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            motor_stop_q   <= 1'b0;
            lockout_q      <= 1'b0;
            detect_pulse_q <= 1'b0;
            detect_count_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            motor_stop_q   <= motor_stop_d;
            lockout_q      <= lockout_d;
            detect_pulse_q <= detect_pulse_d;
            detect_count_q <= detect_count_d;
        end
    end

    assign bus.motor_stop   = motor_stop_q;
    assign bus.lockout      = lockout_q;
    assign bus.detect_pulse = detect_pulse_q;
    assign bus.state        = state_q;
    assign bus.detect_count = detect_count_q;
endmodule
